gray_vertical_census_bank: RTL and testbench
============================================

GRAY_VERTICAL_CENSUS_BANK -- requirements
Module: gray_vertical_census_bank

Interface
REQ-001 SHALL have parameter LANES, default 16: number of independent pixel columns processed per beat.
REQ-002 SHALL have parameter PIX_W, default 8: gray pixel width.
REQ-003 SHALL have parameter RADIUS, default 8: vertical half-window; window length N = 2*RADIUS+1.
REQ-004 SHALL have parameter FRAME_LINES, default 480: beats per column; legal only if FRAME_LINES >= N.
REQ-005 SHALL have parameter INFO_W, default 8: sideband width.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_pixels  input  LANES*PIX_W  lane i at bits [i*PIX_W +: PIX_W].
REQ-009 SHALL have port in_info  input  INFO_W  sideband travelling with the beat.
REQ-010 SHALL have port in_valid  input  1  beat present.
REQ-011 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port cfg_mode  input  1  0 = binary census, 1 = ternary census.
REQ-013 SHALL have port cfg_threshold  input  PIX_W  ternary dead-band T.
REQ-014 SHALL have port out_bits  output  2*LANES  lane i: bit 2i = gt, bit 2i+1 = lt.
REQ-015 SHALL have port out_info  output  INFO_W  in_info of the producing beat.
REQ-016 SHALL have port out_border  output  1  result is border (window incomplete).
REQ-017 SHALL have port out_last  output  1  last beat of a column.
REQ-018 SHALL have port out_valid  output  1  output beat present.
REQ-019 SHALL have port out_ready  input  1  downstream accepts when out_valid and out_ready are both high.

Function
REQ-020 SHALL keep a beat index k (0..FRAME_LINES-1) incremented on each accepted beat, wrapping to 0 after FRAME_LINES-1.
REQ-021 SHALL keep per lane a delay line of the last N accepted pixels and a running sum of width PIX_W+clog2(N), updated on accept: sum += newest - pixel leaving the window.
REQ-022 SHALL never clear the window or sum at column boundaries; border masking alone isolates columns.
REQ-023 SHALL define, for beat k, center = pixel accepted RADIUS beats earlier and window = the last N pixels including beat k.
REQ-024 SHALL compute gt = (N*center > sum + N*Ts) and lt = (N*center + N*Ts < sum), in unsigned arithmetic wide enough to never overflow; Ts is the latched threshold.
REQ-025 SHALL force Ts = 0 and lt = 0 in binary mode; ternary mode uses both bits.
REQ-026 SHALL latch cfg_mode and cfg_threshold on the accept of a beat with k = 0; that setting applies to the whole column, and mid-column changes take effect at the next column.
REQ-027 SHALL, for k < 2*RADIUS, drive the lane bits to 0 and out_border to 1; otherwise out_border = 0.
REQ-028 SHALL drive out_last = 1 exactly for beats with k = FRAME_LINES-1.
REQ-029 SHALL produce exactly one output beat per accepted input beat, in order, with out_info equal to that beat's in_info.
REQ-030 SHALL present an accepted beat at out_valid 2 cycles after acceptance when out_ready is held high: stage 1 updates window and sum, stage 2 compares and registers outputs.
REQ-031 SHALL use a single pipeline enable en = !out_valid | out_ready; in_ready = en; while out_valid is high and out_ready is low, all stages and outputs hold.
REQ-032 SHALL sustain 1 beat/cycle throughput when in_valid and out_ready stay high.

Reset
REQ-033 SHALL, on reset, set out_valid = 0, out_bits = 0, out_border = 0, out_last = 0, out_info = 0, k = 0, all windows and sums = 0, latched mode = 0, latched threshold = 0, and all pipeline valids = 0.
REQ-034 SHALL treat the first beat after reset, including a reset mid-column, as k = 0 of a new column.
REQ-035 SHALL drive in_ready = 1 in the cycle after reset deasserts.

Verification (RADIUS=1, N=3, FRAME_LINES=8, LANES=2, out_ready=1 unless stated)
REQ-036 SHALL cover: lane 0 pixels all 100, binary -> k 0..1 bits 00 with border=1; k 2..7 bits 00 with border=0; out_last only at k=7.
REQ-037 SHALL cover: lane 0 = 10,10,10,40,10,10,10,10, ternary, T=5 -> k=3: lt=1, gt=0; k=4: gt=1, lt=0; k=5: lt=1; k=2: 00.
REQ-038 SHALL cover: same stimulus, binary -> k=3 bits 00 and k=4 gt=1; changing cfg_mode at k=4 has no effect until the next column.
REQ-039 SHALL cover: out_ready low for 5 cycles mid-column -> in_ready low, outputs stable, no beat lost or duplicated, out_info order preserved.
REQ-040 SHALL cover: reset asserted at k=5, then 8 new beats -> first two outputs border=1, out_last at the 8th beat, no stale output from before reset.
REQ-041 SHALL cover: two back-to-back columns at full rate -> 16 outputs, 2-cycle latency each, border set on beats 0,1 and 8,9.

Source files
------------

// File: rtl/gray_vertical_census_bank.sv
// Vertical census transform over LANES independent pixel columns. Each lane keeps
// a sliding N-pixel window and a running sum, and compares the window centre to the mean.
module gray_vertical_census_bank #(
  parameter int LANES       = 16,
  parameter int PIX_W       = 8,
  parameter int RADIUS      = 8,
  parameter int FRAME_LINES = 480,
  parameter int INFO_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES*PIX_W-1:0]   in_pixels,
  input  logic [INFO_W-1:0]        in_info,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     cfg_mode,
  input  logic [PIX_W-1:0]         cfg_threshold,
  output logic [2*LANES-1:0]       out_bits,
  output logic [INFO_W-1:0]        out_info,
  output logic                     out_border,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int N     = 2 * RADIUS + 1;
  localparam int SUM_W = PIX_W + $clog2(N);
  localparam int CMP_W = SUM_W + 2;
  localparam int K_W   = $clog2(FRAME_LINES + 1);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_LINES - 1);
  localparam logic [K_W-1:0]   K_BORDER = K_W'(2 * RADIUS);
  localparam logic [CMP_W-1:0] N_C      = CMP_W'(N);

  logic                  en;
  logic                  accept;
  logic [K_W-1:0]        k;
  logic [K_W-1:0]        s1_k;
  logic                  s1_valid;
  logic [INFO_W-1:0]     s1_info;
  logic [PIX_W-1:0]      win [LANES][N];
  logic [SUM_W-1:0]      sum [LANES];
  logic                  mode_l;
  logic [PIX_W-1:0]      thr_l;

  logic [2*LANES-1:0]    bits_next;
  logic                  border_next;
  logic                  last_next;
  logic [CMP_W-1:0]      ts;

  // One enable for the whole pipeline: everything advances or everything holds.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Stage 1: window shift, running sum, beat index and per-column configuration.
  // Window and sum registers only change on accept, so while a beat sits in stage 1
  // they describe exactly that beat and stage 2 can read them directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the windows are real state feeding the first sums of a column, so they
      // are cleared on reset like any other register rather than left uninitialised.
      for (int i = 0; i < LANES; i++) begin
        for (int j = 0; j < N; j++) win[i][j] <= '0;
        sum[i] <= '0;
      end
      k        <= '0;
      s1_k     <= '0;
      s1_valid <= 1'b0;
      s1_info  <= '0;
      mode_l   <= 1'b0;
      thr_l    <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          for (int j = N - 1; j > 0; j--) win[i][j] <= win[i][j-1];
          win[i][0] <= in_pixels[i*PIX_W +: PIX_W];
          sum[i]    <= sum[i] + SUM_W'(in_pixels[i*PIX_W +: PIX_W]) - SUM_W'(win[i][N-1]);
        end
        if (k == '0) begin
          mode_l <= cfg_mode;
          thr_l  <= cfg_threshold;
        end
        k       <= (k == K_LAST) ? '0 : k + 1'b1;
        s1_k    <= k;
        s1_info <= in_info;
      end
      if (en) s1_valid <= accept;
    end
  end

  // Stage 2 compare; win[i][RADIUS] is the pixel accepted RADIUS beats before s1's beat.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    bits_next   = '0;
    border_next = (s1_k < K_BORDER);
    last_next   = (s1_k == K_LAST);
    ts          = mode_l ? CMP_W'(thr_l) : '0;
    for (int i = 0; i < LANES; i++) begin
      if (!border_next) begin
        bits_next[2*i]   = (N_C * CMP_W'(win[i][RADIUS])) > (CMP_W'(sum[i]) + N_C * ts);
        bits_next[2*i+1] = mode_l &&
                           ((N_C * CMP_W'(win[i][RADIUS]) + N_C * ts) < CMP_W'(sum[i]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_info   <= '0;
      out_border <= 1'b0;
      out_last   <= 1'b0;
    end else if (en) begin
      out_valid  <= s1_valid;
      out_bits   <= bits_next;
      out_info   <= s1_info;
      out_border <= border_next;
      out_last   <= last_next;
    end
  end

endmodule

// File: tb/tb_gray_vertical_census_bank.sv
// Randomised scoreboard bench for gray_vertical_census_bank (RADIUS=1, FRAME_LINES=8, LANES=2).
// A history-based model predicts each beat's result; a separate monitor checks DUT output.
module tb_gray_vertical_census_bank;

  localparam int LANES  = 2;
  localparam int PIX_W  = 8;
  localparam int RADIUS = 1;
  localparam int N      = 2 * RADIUS + 1;
  localparam int FL     = 8;
  localparam int INFO_W = 8;

  logic                   clk;
  logic                   reset;
  logic [LANES*PIX_W-1:0] in_pixels;
  logic [INFO_W-1:0]      in_info;
  logic                   in_valid;
  logic                   in_ready;
  logic                   cfg_mode;
  logic [PIX_W-1:0]       cfg_threshold;
  logic [2*LANES-1:0]     out_bits;
  logic [INFO_W-1:0]      out_info;
  logic                   out_border;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  gray_vertical_census_bank #(
    .LANES(LANES), .PIX_W(PIX_W), .RADIUS(RADIUS), .FRAME_LINES(FL), .INFO_W(INFO_W)
  ) dut (
    .clk(clk), .reset(reset), .in_pixels(in_pixels), .in_info(in_info),
    .in_valid(in_valid), .in_ready(in_ready), .cfg_mode(cfg_mode),
    .cfg_threshold(cfg_threshold), .out_bits(out_bits), .out_info(out_info),
    .out_border(out_border), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [2*LANES-1:0] bits;
    logic [INFO_W-1:0]  info;
    logic               border;
    logic               last;
    int                 acc_cyc;
    bit                 lat_chk;
  } exp_t;

  exp_t                   exp_q[$];
  logic [LANES*PIX_W-1:0] hist[$];   // accepted beats since reset, newest at the back
  int                     k_m;
  bit                     mode_m;
  int                     thr_m;
  bit                     lat_flag;
  exp_t                   e_new;
  int                     m_sum, m_ctr, m_ts;

  // Pixel of a lane accepted 'age' beats ago; nothing accepted yet counts as 0.
  function automatic int px(input int age, input int lane);
    logic [LANES*PIX_W-1:0] v;
    if (age >= hist.size()) return 0;
    v = hist[hist.size() - 1 - age];
    return int'(v[lane*PIX_W +: PIX_W]);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      hist.delete();
      exp_q.delete();
      k_m    = 0;
      mode_m = 0;
      thr_m  = 0;
    end else if (in_valid && in_ready) begin
      if (k_m == 0) begin
        mode_m = cfg_mode;
        thr_m  = int'(cfg_threshold);
      end
      hist.push_back(in_pixels);
      if (hist.size() > N) void'(hist.pop_front());
      e_new.bits    = '0;
      e_new.info    = in_info;
      e_new.border  = (k_m < 2 * RADIUS);
      e_new.last    = (k_m == FL - 1);
      e_new.acc_cyc = cyc;
      e_new.lat_chk = lat_flag;
      m_ts = mode_m ? thr_m : 0;
      for (int l = 0; l < LANES; l++) begin
        m_sum = 0;
        for (int a = 0; a < N; a++) m_sum += px(a, l);
        m_ctr = px(RADIUS, l);
        if (!e_new.border) begin
          e_new.bits[2*l]   = (N * m_ctr > m_sum + N * m_ts);
          e_new.bits[2*l+1] = mode_m && (N * m_ctr + N * m_ts < m_sum);
        end
      end
      exp_q.push_back(e_new);
      k_m = (k_m + 1) % FL;
    end
  end

  // ---------------- monitor ----------------
  exp_t               e_got;
  bit                 stall_prev = 0;
  logic [2*LANES-1:0] p_bits;
  logic [INFO_W-1:0]  p_info;
  logic               p_border, p_last;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid",  out_valid,  1);
        check("stall_bits",   out_bits,   p_bits);
        check("stall_info",   out_info,   p_info);
        check("stall_border", out_border, p_border);
        check("stall_last",   out_last,   p_last);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: info %0d with no beat outstanding", out_info);
        end else begin
          e_got = exp_q.pop_front();
          check("bits",   out_bits,   e_got.bits);
          check("info",   out_info,   e_got.info);
          check("border", out_border, e_got.border);
          check("last",   out_last,   e_got.last);
          if (e_got.lat_chk) check("latency", cyc - e_got.acc_cyc, 2);
        end
      end
      stall_prev = out_valid && !out_ready;
      p_bits   = out_bits;
      p_info   = out_info;
      p_border = out_border;
      p_last   = out_last;
    end
  end

  // ---------------- driver ----------------
  bit       rand_rdy = 0;
  logic [7:0] info_ctr = 0;
  int       pat [8] = '{10, 10, 10, 40, 10, 10, 10, 10};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p0, input logic [7:0] p1);
    bit acc;
    int budget;
    in_pixels = {p1, p0};
    in_info   = info_ctr;
    in_valid  = 1'b1;
    budget    = 0;
    acc       = 0;
    while (!acc && budget < 100) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      step();
      budget++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat info %0d never accepted", info_ctr);
    end
    info_ctr = info_ctr + 1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_bits",   out_bits,   0);
    check("rst_out_border", out_border, 0);
    check("rst_out_last",   out_last,   0);
    check("rst_out_info",   out_info,   0);
    check("rst_in_ready",   in_ready,   1);
    step();
  endtask

  task automatic column_pattern();
    for (int k = 0; k < FL; k++) send(8'(pat[k]), 8'($urandom_range(0, 255)));
  endtask

  int wait_cnt;

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_pixels     = '0;
    in_info       = '0;
    cfg_mode      = 1'b0;
    cfg_threshold = '0;
    out_ready     = 1'b1;
    lat_flag      = 1'b1;
    do_reset();

    // Flat column, binary: no bits anywhere, border on k 0..1, last at k 7.
    cfg_mode = 1'b0;
    for (int k = 0; k < FL; k++) send(8'd100, 8'($urandom_range(0, 255)));

    // Spike pattern, ternary T=5.
    cfg_mode = 1'b1;
    cfg_threshold = 8'd5;
    column_pattern();

    // Same pattern binary, mode flipped to ternary at k=4 (takes effect next column).
    cfg_mode = 1'b0;
    cfg_threshold = 8'd5;
    for (int k = 0; k < FL; k++) begin
      if (k == 4) cfg_mode = 1'b1;
      send(8'(pat[k]), 8'($urandom_range(0, 255)));
    end
    // Next column picks up ternary; a mid-column flip back is ignored.
    for (int k = 0; k < FL; k++) begin
      if (k == 3) cfg_mode = 1'b0;
      send(8'(pat[k]), 8'($urandom_range(0, 255)));
    end

    // Downstream stall of 5 cycles mid-column with a beat pending.
    lat_flag = 1'b0;
    cfg_mode = 1'b1;
    cfg_threshold = 8'd3;
    for (int k = 0; k < 3; k++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    out_ready = 1'b0;
    in_pixels = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    in_info   = info_ctr;
    in_valid  = 1'b1;
    repeat (5) step();
    out_ready = 1'b1;
    for (int k = 3; k < FL; k++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    lat_flag = 1'b1;

    // Reset at k=5 of a column, then a fresh column.
    for (int k = 0; k < 5; k++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    do_reset();
    cfg_mode = 1'b1;
    cfg_threshold = 8'd2;
    for (int k = 0; k < FL; k++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Two back-to-back columns at full rate.
    for (int k = 0; k < 2 * FL; k++) send(8'($urandom_range(80, 120)), 8'($urandom_range(0, 255)));

    // Random traffic: random backpressure, gaps, configuration churn and extreme pixels.
    lat_flag = 1'b0;
    rand_rdy = 1'b1;
    for (int b = 0; b < 20 * FL; b++) begin
      cfg_mode      = 1'($urandom_range(0, 1));
      cfg_threshold = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0)
        send(($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0, 8'($urandom_range(0, 255)));
      else
        send(8'($urandom_range(60, 140)), 8'($urandom_range(60, 140)));
    end

    // Drain outstanding beats.
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    wait_cnt  = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      step();
      wait_cnt++;
    end
    step();
    check("drain_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
